// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM FIFO arbiter.
package sdram_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 24;
  localparam int unsigned DEF_BURST_W = 10;
  localparam int unsigned DEF_USEDW_W = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_BUSY = 3'd2,
    RD_REQ  = 3'd3,
    RD_BUSY = 3'd4
  } arb_state_t;

  localparam logic GRANT_WR = 1'b1;
  localparam logic GRANT_RD = 1'b0;

endpackage

// File: rtl/sdram_addr_gen.sv
// Burst address pointer with frame wrap-around and deferred reload.
module sdram_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_ADDR_W,
  parameter int unsigned BW = DEF_BURST_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] min_addr,
  input  logic [AW-1:0] max_addr,
  input  logic [BW-1:0] len,
  input  logic          load,
  input  logic          idle,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          frame_done
);

  localparam int unsigned NW = AW + 1;

  logic          pending;
  logic          load_now;
  logic [NW-1:0] nxt;

  assign load_now = load || pending;
  assign nxt      = NW'(addr) + NW'(len);

  // A load seen mid-burst replaces that burst's advance and suppresses the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (advance) begin
        pending <= 1'b0;
        if (load_now) begin
          addr <= min_addr;
        end else if (nxt >= NW'(max_addr)) begin
          addr       <= min_addr;
          frame_done <= 1'b1;
        end else begin
          addr <= nxt[AW-1:0];
        end
      end else if (idle && load_now) begin
        addr    <= min_addr;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_fifo_arbiter.sv
// Round-robin burst arbiter between camera write FIFO and display read FIFO.
module sdram_fifo_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned BURST_W = DEF_BURST_W,
  parameter int unsigned USEDW_W = DEF_USEDW_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdram_init_done,
  input  logic [ADDR_W-1:0]  wr_min_addr,
  input  logic [ADDR_W-1:0]  wr_max_addr,
  input  logic [BURST_W-1:0] wr_len,
  input  logic               wr_load,
  input  logic [USEDW_W-1:0] wrf_usedw,
  output logic               wrf_rdreq,
  input  logic [ADDR_W-1:0]  rd_min_addr,
  input  logic [ADDR_W-1:0]  rd_max_addr,
  input  logic [BURST_W-1:0] rd_len,
  input  logic               rd_load,
  input  logic               rd_valid,
  input  logic [USEDW_W-1:0] rdf_usedw,
  output logic               rdf_wrreq,
  output logic               sdram_wr_req,
  input  logic               sdram_wr_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic               sdram_rd_req,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_rd_burst,
  output logic               wr_frame_done,
  output logic               rd_frame_done
);

  arb_state_t state;
  logic       last_grant;
  logic       wr_ack_d, rd_ack_d, init_d;
  logic       wr_need, rd_need, init_rise, in_idle, wr_adv, rd_adv;

  assign wr_need   = wrf_usedw >= USEDW_W'(wr_len);
  assign rd_need   = rd_valid && (rdf_usedw < USEDW_W'(rd_len));
  assign init_rise = sdram_init_done && !init_d;
  assign in_idle   = (state == IDLE);
  assign wr_adv    = (state == WR_BUSY) && wr_ack_d && !sdram_wr_ack;
  assign rd_adv    = (state == RD_BUSY) && rd_ack_d && !sdram_rd_ack;

  // Data moves straight between controller and FIFOs, so strobes mirror the acks.
  assign wrf_rdreq = sdram_wr_ack;
  assign rdf_wrreq = sdram_rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= GRANT_RD;
      wr_ack_d       <= 1'b0;
      rd_ack_d       <= 1'b0;
      init_d         <= 1'b0;
      sdram_wr_req   <= 1'b0;
      sdram_rd_req   <= 1'b0;
      sdram_wr_burst <= '0;
      sdram_rd_burst <= '0;
    end else begin
      wr_ack_d <= sdram_wr_ack;
      rd_ack_d <= sdram_rd_ack;
      init_d   <= sdram_init_done;
      unique case (state)
        IDLE: begin
          // Both sides hungry: hand the grant to whoever did not get the last one.
          if (sdram_init_done) begin
            if (wr_need && (!rd_need || last_grant == GRANT_RD)) begin
              state          <= WR_REQ;
              last_grant     <= GRANT_WR;
              sdram_wr_req   <= 1'b1;
              sdram_wr_burst <= wr_len;
            end else if (rd_need) begin
              state          <= RD_REQ;
              last_grant     <= GRANT_RD;
              sdram_rd_req   <= 1'b1;
              sdram_rd_burst <= rd_len;
            end
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            state        <= WR_BUSY;
            sdram_wr_req <= 1'b0;
          end
        end
        WR_BUSY: begin
          if (wr_adv) state <= IDLE;
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            state        <= RD_BUSY;
            sdram_rd_req <= 1'b0;
          end
        end
        RD_BUSY: begin
          if (rd_adv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sdram_addr_gen #(.AW(ADDR_W), .BW(BURST_W)) u_wr_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .min_addr   (wr_min_addr),
    .max_addr   (wr_max_addr),
    .len        (sdram_wr_burst),
    .load       (wr_load || init_rise),
    .idle       (in_idle),
    .advance    (wr_adv),
    .addr       (sdram_wr_addr),
    .frame_done (wr_frame_done)
  );

  sdram_addr_gen #(.AW(ADDR_W), .BW(BURST_W)) u_rd_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .min_addr   (rd_min_addr),
    .max_addr   (rd_max_addr),
    .len        (sdram_rd_burst),
    .load       (rd_load || init_rise),
    .idle       (in_idle),
    .advance    (rd_adv),
    .addr       (sdram_rd_addr),
    .frame_done (rd_frame_done)
  );

endmodule

// File: tb/tb_sdram_fifo_arbiter.sv
// Scoreboard bench for sdram_fifo_arbiter with a simple controller ack model.
`timescale 1ns/1ps
module tb_sdram_fifo_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned BW = 10;
  localparam int unsigned UW = 11;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [BW-1:0] burst;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic [AW-1:0] wr_min = '0, wr_max = '0, rd_min = '0, rd_max = '0;
  logic [BW-1:0] wr_len = '0, rd_len = '0;
  logic          wr_load = 1'b0, rd_load = 1'b0, rd_valid = 1'b0;
  logic [UW-1:0] wrf_usedw = '0, rdf_usedw = '0;
  logic          wr_ack_drv = 1'b0, rd_ack_drv = 1'b0;
  logic          wr_ack, rd_ack;
  logic          wrf_rdreq, rdf_wrreq, wr_req, rd_req, wr_fd, rd_fd;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_burst, rd_burst;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   overlap = 0, noinit_req = 0;
  int   wr_strobe_cnt = 0, rd_strobe_cnt = 0;
  int   wr_fd_cnt = 0, rd_fd_cnt = 0, wr_fd_at = -1;
  int   wr_done_cnt = 0;
  bit   ctl_busy = 1'b0;
  logic wr_req_p = 1'b0, rd_req_p = 1'b0;

  // The controller shares rst_n, so its acks vanish with reset.
  assign wr_ack = wr_ack_drv && rst_n;
  assign rd_ack = rd_ack_drv && rst_n;

  always #5 clk = ~clk;

  sdram_fifo_arbiter dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .wr_min_addr(wr_min), .wr_max_addr(wr_max), .wr_len(wr_len), .wr_load(wr_load),
    .wrf_usedw(wrf_usedw), .wrf_rdreq(wrf_rdreq),
    .rd_min_addr(rd_min), .rd_max_addr(rd_max), .rd_len(rd_len), .rd_load(rd_load),
    .rd_valid(rd_valid), .rdf_usedw(rdf_usedw), .rdf_wrreq(rdf_wrreq),
    .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack), .sdram_wr_addr(wr_addr), .sdram_wr_burst(wr_burst),
    .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack), .sdram_rd_addr(rd_addr), .sdram_rd_burst(rd_burst),
    .wr_frame_done(wr_fd), .rd_frame_done(rd_fd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_req(input logic rd, input int addr, input int burst);
    exp_q.push_back('{rd: rd, addr: AW'(addr), burst: BW'(burst)});
  endtask

  task automatic sb_pop(input logic rd, input logic [AW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_unexpected: side %0d addr %0d burst %0d, nothing expected", rd, a, b);
    end else begin
      e = exp_q.pop_front();
      check("sb_side", 64'(rd), 64'(e.rd));
      check("sb_addr", 64'(a), 64'(e.addr));
      check("sb_burst", 64'(b), 64'(e.burst));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates and driver changes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_req && !wr_req_p) sb_pop(1'b0, wr_addr, wr_burst);
      if (rd_req && !rd_req_p) sb_pop(1'b1, rd_addr, rd_burst);
      if (wr_req && rd_req) overlap++;
      if (!init_done && wr_req) noinit_req++;
      if (wrf_rdreq) wr_strobe_cnt++;
      if (rdf_wrreq) rd_strobe_cnt++;
      if (wr_fd) begin wr_fd_cnt++; wr_fd_at = wr_done_cnt; end
      if (rd_fd) rd_fd_cnt++;
    end
    wr_req_p = wr_req;
    rd_req_p = rd_req;
  end

  // Controller model: two cycles latency, then one ack per burst word.
  task automatic serve(input logic rd);
    int n, s0, late_req;
    n = rd ? int'(rd_burst) : int'(wr_burst);
    s0 = rd ? rd_strobe_cnt : wr_strobe_cnt;
    late_req = 0;
    ctl_busy = 1'b1;
    cyc(2);
    for (int i = 0; i < n; i++) begin
      if (!rst_n) break;
      if (rd) rd_ack_drv = 1'b1; else wr_ack_drv = 1'b1;
      cyc(1);
      if (i == 0 && rst_n) check(rd ? "rd_req_drop" : "wr_req_drop", 64'(rd ? rd_req : wr_req), 64'd0);
      else if (wr_req || rd_req) late_req++;
    end
    wr_ack_drv = 1'b0;
    rd_ack_drv = 1'b0;
    if (rst_n) begin
      check(rd ? "rdf_wrreq_count" : "wrf_rdreq_count",
            64'(rd ? rd_strobe_cnt - s0 : wr_strobe_cnt - s0), 64'(n));
      check("req_during_ack", 64'(late_req), 64'd0);
      if (!rd) wr_done_cnt++;
    end
    ctl_busy = 1'b0;
  endtask

  initial begin
    forever begin
      cyc(1);
      if (rst_n && wr_req) serve(1'b0);
      else if (rst_n && rd_req) serve(1'b1);
    end
  end

  task automatic wait_q_empty(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin cyc(1); t++; end
    if (exp_q.size() != 0) check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_q_size(input string name, input int sz, input int budget);
    int t = 0;
    while (exp_q.size() > sz && t < budget) begin cyc(1); t++; end
    if (exp_q.size() > sz) check({name, "_timeout"}, 64'(exp_q.size()), 64'(sz));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while ((ctl_busy || wr_req || rd_req) && t < budget) begin cyc(1); t++; end
    if (ctl_busy || wr_req || rd_req) check({name, "_idle_timeout"}, 64'(t), 64'(budget - 1));
    cyc(3);
  endtask

  task automatic wait_ack(input logic rd, input int budget);
    int t = 0;
    while (!(rd ? rd_ack : wr_ack) && t < budget) begin cyc(1); t++; end
    check(rd ? "rd_ack_seen" : "wr_ack_seen", 64'(rd ? rd_ack : wr_ack), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({wr_req, rd_req, wr_burst, rd_burst, wr_fd, rd_fd, wrf_rdreq, rdf_wrreq}), 64'd0);
    check({name, "_addr"}, 64'({wr_addr, rd_addr}), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int fd0;
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Init gating, then three 512-word write bursts wrapping a 1024-word frame.
    wr_min = 0; wr_max = 1024; wr_len = 512; wrf_usedw = 600;
    rd_min = 2048; rd_max = 3072; rd_len = 512; rd_valid = 1'b0; rdf_usedw = 0;
    cyc(100);
    check("no_req_before_init", 64'(noinit_req), 64'd0);
    expect_req(1'b0, 0, 512);
    expect_req(1'b0, 512, 512);
    expect_req(1'b0, 0, 512);
    init_done = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      @(negedge clk);
      if (wr_req) got = 1'b1;
    end
    check("wr_req_after_init", 64'(got), 64'd1);
    check("wr_addr_after_init", 64'(wr_addr), 64'd0);
    wait_q_empty("wr_frame", 3000);
    wrf_usedw = 0;
    wait_idle("wr_frame", 1000);
    check("wr_frame_done_count", 64'(wr_fd_cnt), 64'd1);
    check("wr_frame_done_after_burst", 64'(wr_fd_at), 64'd2);

    // Both sides hungry: grants alternate, starting with read after the write run.
    wr_len = 4; rd_len = 4;
    expect_req(1'b1, 2048, 4);
    expect_req(1'b0, 512, 4);
    expect_req(1'b1, 2052, 4);
    expect_req(1'b0, 516, 4);
    wrf_usedw = 600; rd_valid = 1'b1; rdf_usedw = 0;
    wait_q_empty("round_robin", 500);
    wrf_usedw = 0; rd_valid = 1'b0;
    wait_idle("round_robin", 200);

    // Reload mid read burst: burst completes at 512, next burst restarts at min.
    rd_min = 0; rd_max = 2048; rd_len = 512;
    rd_load = 1'b1; cyc(1); rd_load = 1'b0;
    check("rd_addr_after_idle_load", 64'(rd_addr), 64'd0);
    expect_req(1'b1, 0, 512);
    expect_req(1'b1, 512, 512);
    expect_req(1'b1, 0, 512);
    fd0 = rd_fd_cnt;
    rd_valid = 1'b1;
    wait_q_size("rd_load_b2", 1, 1200);
    wait_ack(1'b1, 10);
    rd_load = 1'b1; cyc(1); rd_load = 1'b0;
    cyc(2);
    check("rd_addr_held_mid_burst", 64'(rd_addr), 64'd512);
    wait_q_empty("rd_load", 1200);
    rd_valid = 1'b0;
    wait_idle("rd_load", 1000);
    check("rd_frame_done_suppressed", 64'(rd_fd_cnt - fd0), 64'd0);

    // Asynchronous reset during a write burst, then restart from new min addresses.
    wr_len = 8; wrf_usedw = 600;
    expect_req(1'b0, 520, 8);
    wait_q_empty("pre_reset", 50);
    wait_ack(1'b0, 10);
    cyc(2);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    init_done = 1'b0;
    wr_min = 100; wr_max = 1124;
    rd_min = 3000; rd_max = 4000; rd_len = 8; rd_valid = 1'b1; rdf_usedw = 0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    check("wr_addr_cleared", 64'(wr_addr), 64'd0);
    expect_req(1'b0, 100, 8);
    expect_req(1'b1, 3000, 8);
    init_done = 1'b1;
    wait_q_empty("post_reset", 200);
    wrf_usedw = 0; rd_valid = 1'b0;
    wait_idle("post_reset", 200);

    check("req_overlap", 64'(overlap), 64'd0);
    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
